pipe_rcla_adder: RTL and testbench

//  Parametrised, pipelined ripple-block carry look-ahead adder/subtractor with valid/ready handshake.

---
 rtl/pipe_rcla_adder_if.sv | 25 ++
 rtl/pipe_rcla_adder.sv | 119 +++++++++++
 tb/tb_pipe_rcla_adder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_rcla_adder_if.sv
// Operand/result handshake bundle for pipe_rcla_adder.
// master = producer/consumer side, slave = adder side.
interface pipe_rcla_adder_if #(
  parameter int WIDTH = 9
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   s;

  modport master (
    output in_valid, x, y, cin, sub, out_ready,
    input  in_ready, out_valid, s
  );

  modport slave (
    input  in_valid, x, y, cin, sub, out_ready,
    output in_ready, out_valid, s
  );
endinterface

// File: rtl/pipe_rcla_adder.sv
// Pipelined ripple-block carry look-ahead adder/subtractor.
// One register stage after every BPS look-ahead blocks.
module pipe_rcla_adder #(
  parameter int WIDTH = 9,
  parameter int BLK   = 4,
  parameter int BPS   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  pipe_rcla_adder_if.slave bus
);
  localparam int NB = (WIDTH + BLK - 1) / BLK;
  localparam int NS = (NB + BPS - 1) / BPS;

  logic             vld_q [NS];
  logic             vld_d [NS];
  logic [WIDTH-1:0] x_q   [NS];
  logic [WIDTH-1:0] x_d   [NS];
  logic [WIDTH-1:0] y_q   [NS];
  logic [WIDTH-1:0] y_d   [NS];
  logic [WIDTH-1:0] sum_q [NS];
  logic [WIDTH-1:0] sum_d [NS];
  logic             cy_q  [NS];
  logic             cy_d  [NS];

  logic             vin   [NS];
  logic [WIDTH-1:0] xin   [NS];
  logic [WIDTH-1:0] yin   [NS];
  logic [WIDTH-1:0] sin   [NS];
  logic             cin_s [NS];

  logic adv;

  assign adv           = ~vld_q[NS-1] | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[NS-1];
  assign bus.s         = {cy_q[NS-1], sum_q[NS-1]};

  always_comb begin
    vin[0]   = bus.in_valid;
    xin[0]   = bus.x;
    yin[0]   = bus.sub ? ~bus.y : bus.y;
    sin[0]   = '0;
    cin_s[0] = bus.sub | bus.cin;
    for (int k = 1; k < NS; k++) begin
      vin[k]   = vld_q[k-1];
      xin[k]   = x_q[k-1];
      yin[k]   = y_q[k-1];
      sin[k]   = sum_q[k-1];
      cin_s[k] = cy_q[k-1];
    end
  end

  always_comb begin
    logic [WIDTH-1:0] si;
    logic c_run, bc, gg, pp, ci, g, p;
    si    = '0;
    c_run = 1'b0;
    bc    = 1'b0;
    gg    = 1'b0;
    pp    = 1'b1;
    ci    = 1'b0;
    g     = 1'b0;
    p     = 1'b0;
    for (int k = 0; k < NS; k++) begin
      si    = sin[k];
      c_run = cin_s[k];
      bc    = c_run;
      gg    = 1'b0;
      pp    = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
        if ((i / BLK) / BPS == k) begin
          // gg/pp: group generate/propagate of block bits below i
          if (i % BLK == 0) begin
            bc = c_run;
            gg = 1'b0;
            pp = 1'b1;
          end
          g     = xin[k][i] & yin[k][i];
          p     = xin[k][i] ^ yin[k][i];
          ci    = gg | (pp & bc);
          si[i] = p ^ ci;
          gg    = g | (p & gg);
          pp    = pp & p;
          if ((i % BLK == BLK - 1) ||
              (i == WIDTH - 1)) begin
            c_run = gg | (pp & bc);
          end
        end
      end
      vld_d[k] = vin[k];
      // payload only moves with a real beat so s holds across bubbles
      x_d[k]   = vin[k] ? xin[k] : x_q[k];
      y_d[k]   = vin[k] ? yin[k] : y_q[k];
      sum_d[k] = vin[k] ? si     : sum_q[k];
      cy_d[k]  = vin[k] ? c_run  : cy_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NS; k++) begin
        vld_q[k] <= 1'b0;
        x_q[k]   <= '0;
        y_q[k]   <= '0;
        sum_q[k] <= '0;
        cy_q[k]  <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < NS; k++) begin
        vld_q[k] <= vld_d[k];
        x_q[k]   <= x_d[k];
        y_q[k]   <= y_d[k];
        sum_q[k] <= sum_d[k];
        cy_q[k]  <= cy_d[k];
      end
    end
  end
endmodule

// File: tb/tb_pipe_rcla_adder.sv
// Directed and random checks of pipe_rcla_adder
// against a scoreboard of reference sums.
module tb_pipe_rcla_adder;
  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  task automatic chk(string tag,
                     logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(
    int w, logic [63:0] a, logic [63:0] b,
    logic ci, logic sb);
    logic [63:0] m;
    logic [63:0] r;
    m = (64'd1 << w) - 64'd1;
    if (sb) r = (a & m) + (~b & m) + 64'd1;
    else    r = (a & m) + (b & m) + {63'd0, ci};
    return r & ((m << 1) | 64'd1);
  endfunction

  pipe_rcla_adder_if #(.WIDTH(9)) m();

  pipe_rcla_adder #(
    .WIDTH(9), .BLK(4), .BPS(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (m.slave)
  );

  logic [63:0] q[$];
  int n_out = 0;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      q.delete();
    end else begin
      if (m.out_valid && m.out_ready) begin
        if (q.size() == 0)
          chk("spurious_out", m.out_valid, 0);
        else begin
          chk("sb", m.s, q.pop_front());
          n_out++;
        end
      end
      if (m.in_valid && m.in_ready)
        q.push_back(model(9, m.x, m.y,
                          m.cin, m.sub));
    end
  end

  localparam int CW [4] = '{1, 16, 33, 32};
  localparam int CB [4] = '{1, 4, 8, 32};
  localparam int CP [4] = '{1, 2, 3, 1};

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int W = CW[g];
    pipe_rcla_adder_if #(.WIDTH(W)) b();
    pipe_rcla_adder #(
      .WIDTH(W), .BLK(CB[g]), .BPS(CP[g])
    ) u (
      .clk  (clk),
      .rst_n(rst2_n),
      .bus  (b.slave)
    );
    logic [63:0] cq[$];
    bit done = 1'b0;

    always @(negedge clk) begin
      if (rst2_n !== 1'b1) begin
        cq.delete();
      end else begin
        if (b.out_valid && b.out_ready) begin
          if (cq.size() == 0)
            chk($sformatf("cfg%0d_spurious", g),
                b.out_valid, 0);
          else
            chk($sformatf("cfg%0d_sb", g),
                b.s, cq.pop_front());
        end
        if (b.in_valid && b.in_ready)
          cq.push_back(model(W, b.x, b.y,
                             b.cin, b.sub));
      end
    end

    initial begin
      b.in_valid  = 1'b0;
      b.x         = '0;
      b.y         = '0;
      b.cin       = 1'b0;
      b.sub       = 1'b0;
      b.out_ready = 1'b1;
      @(posedge rst2_n);
      @(posedge clk); #2;
      repeat (1500) begin
        b.in_valid  = $urandom_range(0, 3) != 0;
        b.x         = W'({$urandom, $urandom});
        b.y         = W'({$urandom, $urandom});
        b.cin       = 1'($urandom_range(0, 1));
        b.sub       = 1'($urandom_range(0, 1));
        b.out_ready = $urandom_range(0, 3) != 0;
        @(posedge clk); #2;
      end
      b.in_valid  = 1'b0;
      b.out_ready = 1'b1;
      for (int i = 0; i < 40 && cq.size() != 0; i++)
        @(posedge clk);
      #3;
      chk($sformatf("cfg%0d_drained", g),
          cq.size(), 0);
      done = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send_one(logic [8:0] a,
                          logic [8:0] bb,
                          logic ci, logic sb,
                          logic [9:0] e,
                          string tag);
    m.in_valid  = 1'b1;
    m.x         = a;
    m.y         = bb;
    m.cin       = ci;
    m.sub       = sb;
    m.out_ready = 1'b1;
    @(posedge clk); #1;
    m.in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat1"}, m.out_valid, 0);
    @(negedge clk);
    chk({tag, "_lat2"}, m.out_valid, 0);
    @(negedge clk);
    chk({tag, "_valid"}, m.out_valid, 1);
    chk({tag, "_s"}, m.s, e);
    cyc();
  endtask

  initial begin
    bit         pst;
    logic [9:0] ps;
    int         sent;
    int         base;
    bit         hv [32];
    bit         all;

    rst_n       = 1'b0;
    rst2_n      = 1'b0;
    m.in_valid  = 1'b0;
    m.x         = '0;
    m.y         = '0;
    m.cin       = 1'b0;
    m.sub       = 1'b0;
    m.out_ready = 1'b1;
    cyc();
    @(negedge clk);
    chk("rst_out_valid", m.out_valid, 0);
    chk("rst_s", m.s, 0);
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    cyc();
    @(negedge clk);
    chk("rst_in_ready", m.in_ready, 1);
    chk("rst_idle_valid", m.out_valid, 0);
    cyc();

    send_one(9'h1FF, 9'h001, 0, 0, 10'h200, "c1a");
    send_one(9'h1FF, 9'h1FF, 1, 0, 10'h3FF, "c1b");
    send_one(9'd5, 9'd7, 0, 1, 10'h1FE, "sub_a");
    send_one(9'd7, 9'd5, 0, 1, 10'h202, "sub_b");
    send_one(9'd5, 9'd7, 1, 1, 10'h1FE, "sub_c");
    send_one(9'd7, 9'd5, 1, 1, 10'h202, "sub_d");
    @(negedge clk);
    chk("hold_idle_v", m.out_valid, 0);
    chk("hold_idle_s", m.s, 10'h202);
    cyc();

    // back-pressure: consumer stalls cycles 2..5
    pst  = 1'b0;
    ps   = '0;
    sent = 0;
    base = n_out;
    for (int c = 0; sent < 8 && c < 100; c++) begin
      m.in_valid  = 1'b1;
      m.x         = 9'(sent);
      m.y         = 9'h0FF;
      m.cin       = 1'b0;
      m.sub       = 1'b0;
      m.out_ready = !(c >= 2 && c < 6);
      @(negedge clk);
      if (pst) begin
        chk("bp_hold_s", m.s, ps);
        chk("bp_hold_v", m.out_valid, 1);
      end
      if (m.out_valid && !m.out_ready)
        chk("bp_in_ready", m.in_ready, 0);
      pst = m.out_valid && !m.out_ready;
      ps  = m.s;
      if (m.in_ready) sent++;
      cyc();
    end
    m.in_valid  = 1'b0;
    m.out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++)
      cyc();
    cyc();
    chk("bp_sent", sent, 8);
    chk("bp_delivered", n_out - base, 8);
    chk("bp_drained", q.size(), 0);

    // reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      m.in_valid = 1'b1;
      m.x        = 9'(10 + i);
      m.y        = 9'd3;
      cyc();
    end
    m.in_valid = 1'b0;
    rst_n      = 1'b0;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_out_valid", m.out_valid, 0);
    chk("mrst_s", m.s, 0);
    chk("mrst_in_ready", m.in_ready, 1);
    cyc();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mrst_no_stale", m.out_valid, 0);
      cyc();
    end

    // bubbles propagate unchanged with 3-cycle offset
    for (int c = 0; c < 20; c++) begin
      m.in_valid = (c % 2) == 0;
      m.x        = 9'(c * 7);
      m.y        = 9'(c * 13);
      m.sub      = 1'(c % 3);
      hv[c]      = m.in_valid;
      @(negedge clk);
      if (c >= 3)
        chk("bubble", m.out_valid, hv[c-3]);
      cyc();
    end
    m.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) cyc();

    for (int c = 0; c < 2000; c++) begin
      m.in_valid  = $urandom_range(0, 1) != 0;
      m.x         = 9'($urandom);
      m.y         = 9'($urandom);
      m.cin       = 1'($urandom_range(0, 1));
      m.sub       = 1'($urandom_range(0, 1));
      m.out_ready = $urandom_range(0, 2) != 0;
      cyc();
    end
    m.in_valid  = 1'b0;
    m.out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++)
      cyc();
    cyc();
    chk("rand_drained", q.size(), 0);

    all = 1'b0;
    for (int i = 0; i < 20000 && !all; i++) begin
      all = g_cfg[0].done && g_cfg[1].done &&
            g_cfg[2].done && g_cfg[3].done;
      if (!all) @(posedge clk);
    end
    chk("cfg_all_done", {63'd0, all}, 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
